npu_act_wr_arbiter: RTL
=======================

Name: npu_act_wr_arbiter

Overview:
- Responder end of the neuron write-back handshake: `hw_mem_wr` / `hw_mem_wr_addr` / `hw_mem_wr_data` / `hw_mem_wr_ack_p`.
- Accepts latched write requests from NUM_NEURONS neuron instances and arbitrates them round-robin.
- Issues one write per cycle into the shared activation memory and returns a one-cycle ack pulse to the winning neuron.
- Sits between the neuron array and the activation BRAM; also counts the writes completed in the current layer.

Parameters:
- NUM_NEURONS, 8, number of requesting neurons (2..16).
- ADDR_WIDTH, `LOG2_ACT_ADDR_WIDTH, activation memory address width.
- DATA_WIDTH, 8, activation data width.
- ACT_MEM_DEPTH, 2**ADDR_WIDTH, number of valid activation words.
- CNT_WIDTH, 16, width of the write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hw_mem_wr  in  NUM_NEURONS  per-neuron write request; each neuron holds it high until acked.
- hw_mem_wr_addr  in  NUM_NEURONS*ADDR_WIDTH  flattened addresses; neuron i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- hw_mem_wr_data  in  NUM_NEURONS*DATA_WIDTH  flattened data, same packing.
- hw_mem_wr_ack_p  out  NUM_NEURONS  one-cycle ack pulse per neuron.
- act_mem_we  out  1  activation memory write enable.
- act_mem_addr  out  ADDR_WIDTH  activation memory write address.
- act_mem_wdata  out  DATA_WIDTH  activation memory write data.
- wr_cnt_clr  in  1  pulse that clears the write counter (layer start).
- wr_cnt  out  CNT_WIDTH  number of writes committed since the last clear; saturates.
- arb_idle  out  1  high when there is no pending request and no write in flight.
- wr_oob_err  out  1  sticky out-of-range address flag (optional feature).

Behaviour:
- Reset: all outputs are 0, except arb_idle = 1. Round-robin pointer = 0. Any grant in flight is dropped and its ack is never issued.
- Pipeline:
  - Cycle N: eligible requests are sampled and the winner's index, address and data are registered.
  - Cycle N+1: act_mem_we = 1 with the registered address/data, and hw_mem_wr_ack_p[winner] = 1 for exactly one cycle.
  - Latency from request to ack is 1 cycle when uncontended.
- Eligibility: eligible = hw_mem_wr & ~hw_mem_wr_ack_p (registered).
  - The requester being acked in cycle N+1 still shows its request high and must not be regranted in that cycle.
  - A neuron's next request is therefore grantable no earlier than N+2.
- Round-robin:
  - Priority search starts at the pointer and wraps from NUM_NEURONS-1 to 0.
  - After a grant to index g, pointer = (g+1) mod NUM_NEURONS. The pointer holds when there is no grant.
- Throughput: sustains one write per cycle while at least one eligible requester exists.
- Starvation bound: with all neurons requesting, each is acked within NUM_NEURONS+1 cycles.
- Holding: no grant leaves act_mem_we = 0 and all acks 0. act_mem_addr/act_mem_wdata hold their last values.
- wr_cnt:
  - Increments on each cycle with act_mem_we = 1.
  - Saturates at all-ones.
  - wr_cnt_clr has priority, but a write in the same cycle loads 1, not 0.
- arb_idle = ~|hw_mem_wr & ~act_mem_we.
- Requests deasserted without an ack are a protocol violation and are not checked. The grant, if already registered, still completes.

Optional Feature:
- Macro: NPU_ACT_WR_BOUNDS_CHK_EN.
- Defined:
  - A granted write with address >= ACT_MEM_DEPTH is still acked (the neuron does not hang).
  - act_mem_we stays 0 for that write and wr_cnt does not increment.
  - wr_oob_err sets and stays set until rst.
- Undefined: addresses pass through unchecked and wr_oob_err is tied to 0.
- The check only matters when ACT_MEM_DEPTH < 2**ADDR_WIDTH.

Decomposition:
- Package / npu_defines.vh: LOG2_ACT_ADDR_WIDTH and ACT_MEM_DEPTH default, plus a macro for flattened-bus slice width.
- One sub-module: npu_rr_arbiter.
  - Parameter N; inputs req[N], ptr; outputs grant_vld and grant_idx.
  - Combinational masked-priority search, reused later for the read-side feeder.

Test Plan:
- Single request: neuron 3 asserts hw_mem_wr with addr 0x010, data 0x5A at cycle 0 -> act_mem_we/ack_p[3] at cycle 1 with addr 0x010, data 0x5A; wr_cnt = 1; arb_idle returns to 1 at cycle 2.
- All 8 neurons request at once from reset, each holding until acked -> acks in order 0,1,...,7 on consecutive cycles 1..8; 8 memory writes with matching addr/data; wr_cnt = 8.
- Neuron 2 re-requests immediately after its ack while neuron 5 is also requesting -> neuron 2 is never double-acked; grants alternate 5,2 according to the pointer; no write is duplicated.
- wr_cnt_clr in the same cycle as a write -> wr_cnt = 1. Separately, preload with CNT_WIDTH = 4 and run 20 writes -> wr_cnt = 15.
- rst asserted the cycle after a grant -> no ack and no act_mem_we afterward; pointer = 0; all outputs at reset values.
- With NPU_ACT_WR_BOUNDS_CHK_EN and ACT_MEM_DEPTH = 100: write to addr 120 -> ack pulses, act_mem_we = 0, wr_oob_err = 1 stays set; wr_cnt unchanged.

Source files
------------

// File: rtl/npu_act_wr_arbiter_pkg.sv
// Shared constants and helpers for the activation write-back arbiter and its round-robin core.
`ifndef LOG2_ACT_ADDR_WIDTH
`define LOG2_ACT_ADDR_WIDTH 10
`endif

`ifndef NPU_FLAT_W
`define NPU_FLAT_W(n, w) ((n) * (w))
`endif

package npu_act_wr_arbiter_pkg;

  localparam int LOG2_ACT_ADDR_WIDTH   = `LOG2_ACT_ADDR_WIDTH;
  localparam int ACT_MEM_DEPTH_DEFAULT = 2 ** LOG2_ACT_ADDR_WIDTH;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_act_wr_arbiter_rr.sv
// Combinational round-robin priority search: lowest requester at or above ptr, else lowest overall.
module npu_rr_arbiter
  import npu_act_wr_arbiter_pkg::*;
#(
  parameter int  N  = 8,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_vld,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] masked;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  // The masked search overrides the unmasked one, which only matters when we wrap past N-1.
  always_comb begin
    grant_vld = |req;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) grant_idx = IW'(i);
    end
  end

endmodule

// File: rtl/npu_act_wr_arbiter.sv
// Round-robin write-back arbiter from the neuron array into the activation memory.
// Optional bounds check on write addresses: define NPU_ACT_WR_BOUNDS_CHK_EN.
module npu_act_wr_arbiter
  import npu_act_wr_arbiter_pkg::*;
#(
  parameter int NUM_NEURONS   = 8,
  parameter int ADDR_WIDTH    = LOG2_ACT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = 8,
  parameter int ACT_MEM_DEPTH = 2 ** ADDR_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_NEURONS-1:0]                        hw_mem_wr,
  input  logic [`NPU_FLAT_W(NUM_NEURONS, ADDR_WIDTH)-1:0] hw_mem_wr_addr,
  input  logic [`NPU_FLAT_W(NUM_NEURONS, DATA_WIDTH)-1:0] hw_mem_wr_data,
  output logic [NUM_NEURONS-1:0]                        hw_mem_wr_ack_p,
  output logic                                          act_mem_we,
  output logic [ADDR_WIDTH-1:0]                         act_mem_addr,
  output logic [DATA_WIDTH-1:0]                         act_mem_wdata,
  input  logic                                          wr_cnt_clr,
  output logic [CNT_WIDTH-1:0]                          wr_cnt,
  output logic                                          arb_idle,
  output logic                                          wr_oob_err
);

  localparam int IW = idx_width(NUM_NEURONS);

`ifdef NPU_ACT_WR_BOUNDS_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic [NUM_NEURONS-1:0] eligible;
  logic [NUM_NEURONS-1:0] ack_next;
  logic                   grant_vld;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          ptr;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   addr_ok;

  // A neuron being acked this cycle still shows its request, so it is masked out here.
  assign eligible = hw_mem_wr & ~hw_mem_wr_ack_p;

  npu_rr_arbiter #(.N(NUM_NEURONS)) u_rr (
    .req       (eligible),
    .ptr       (ptr),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  assign sel_addr = hw_mem_wr_addr[grant_idx * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data = hw_mem_wr_data[grant_idx * DATA_WIDTH +: DATA_WIDTH];
  assign addr_ok  = !CHK_EN || (longint'(sel_addr) < longint'(ACT_MEM_DEPTH));

  always_comb begin
    ack_next = '0;
    if (grant_vld) ack_next[grant_idx] = 1'b1;
  end

  // Out-of-range grants are still acked so the neuron never hangs; only the memory write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      hw_mem_wr_ack_p <= '0;
      act_mem_we      <= 1'b0;
      act_mem_addr    <= '0;
      act_mem_wdata   <= '0;
    end else begin
      hw_mem_wr_ack_p <= ack_next;
      act_mem_we      <= grant_vld && addr_ok;
      if (grant_vld) begin
        act_mem_addr  <= sel_addr;
        act_mem_wdata <= sel_data;
        ptr           <= (grant_idx == IW'(NUM_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // A clear coinciding with a committed write still counts that write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (wr_cnt_clr) begin
      wr_cnt <= act_mem_we ? CNT_WIDTH'(1) : '0;
    end else if (act_mem_we && !(&wr_cnt)) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign arb_idle = ~|hw_mem_wr & ~act_mem_we;

`ifdef NPU_ACT_WR_BOUNDS_CHK_EN
  logic oob_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else if (grant_vld && !addr_ok) begin
      oob_q <= 1'b1;
    end
  end

  assign wr_oob_err = oob_q;
`else
  assign wr_oob_err = 1'b0;
`endif

endmodule
